// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, qualifies lock and releases a clean system reset.
// Optional lock-timeout retry is compiled in when the macro PLL_SUP_RETRY_EN is defined.
module pll_lock_supervisor #(
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int CNT_W               = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             clear_counts,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             sys_ready,
    output logic [CNT_W-1:0] lock_loss_count,
    output logic [CNT_W-1:0] retry_count
);

    typedef enum logic [1:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

`ifdef PLL_SUP_RETRY_EN
    localparam int CYC_MAX = max_int(max_int(PLL_RST_CYCLES, LOCK_STABLE_CYCLES), LOCK_TIMEOUT_CYCLES);
`else
    localparam int CYC_MAX = max_int(PLL_RST_CYCLES, LOCK_STABLE_CYCLES);
`endif
    localparam int CYC_W = $clog2(CYC_MAX + 1);

    localparam logic [CYC_W-1:0] CYC_ONE     = CYC_W'(1);
    localparam logic [CYC_W-1:0] RST_LAST    = CYC_W'(PLL_RST_CYCLES);
    localparam logic [CYC_W-1:0] STABLE_LAST = CYC_W'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_SUP_RETRY_EN
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (LOCK_STABLE_CYCLES < 1) begin : g_bad_stable
        $error("LOCK_STABLE_CYCLES must be at least 1");
    end
    if (LOCK_TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("LOCK_TIMEOUT_CYCLES must be at least 1");
    end
    if (PLL_RST_CYCLES < 1) begin : g_bad_rst
        $error("PLL_RST_CYCLES must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic             sync_meta;
    logic             lk;
    state_t           state;
    state_t           next_state;
    logic [CYC_W-1:0] cyc;
    logic [CYC_W-1:0] cyc_next;
    logic             pll_rst_d;
    logic             sys_ready_d;
    logic             lock_loss_evt;

    // Clear has priority; a clear coinciding with an event leaves the event counted once.
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur,
                                                    input logic clr, input logic evt);
        if (clr)
            return evt ? CNT_ONE : '0;
        if (evt && (cur != CNT_MAX))
            return cur + CNT_ONE;
        return cur;
    endfunction

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            lk        <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            lk        <= sync_meta;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_PLL_RST;
            cyc   <= '0;
        end else begin
            state <= next_state;
            cyc   <= cyc_next;
        end
    end

    // Entering PLL_RST loads 1 because the entry edge is already the first pulse cycle;
    // out of reset the pulse is counted from edge 0 starting at 0.
    always_comb begin
        next_state = state;
        cyc_next   = cyc;
        case (state)
            ST_PLL_RST: begin
                if (cyc == RST_LAST) begin
                    next_state = ST_WAIT_LOCK;
                    cyc_next   = '0;
                end else begin
                    cyc_next = cyc + CYC_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (lk) begin
                    next_state = ST_STABLE;
                    cyc_next   = '0;
                end
`ifdef PLL_SUP_RETRY_EN
                else if (cyc == TIMEOUT_LAST) begin
                    next_state = ST_PLL_RST;
                    cyc_next   = CYC_ONE;
                end else begin
                    cyc_next = cyc + CYC_ONE;
                end
`else
                else begin
                    cyc_next = '0;
                end
`endif
            end
            ST_STABLE: begin
                if (!lk) begin
                    next_state = ST_WAIT_LOCK;
                    cyc_next   = '0;
                end else if (cyc == STABLE_LAST) begin
                    next_state = ST_RUN;
                    cyc_next   = '0;
                end else begin
                    cyc_next = cyc + CYC_ONE;
                end
            end
            ST_RUN: begin
                if (!lk) begin
                    next_state = ST_PLL_RST;
                    cyc_next   = CYC_ONE;
                end else begin
                    cyc_next = '0;
                end
            end
            default: begin
                next_state = ST_PLL_RST;
                cyc_next   = '0;
            end
        endcase
    end

    // Outputs decode the next state so the registered outputs line up with the state register.
    always_comb begin
        pll_rst_d   = 1'b0;
        sys_ready_d = 1'b0;
        case (next_state)
            ST_PLL_RST: pll_rst_d   = 1'b1;
            ST_RUN:     sys_ready_d = 1'b1;
            default: begin
                pll_rst_d   = 1'b0;
                sys_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            sys_ready <= 1'b0;
        end else begin
            pll_rst   <= pll_rst_d;
            sys_rst_n <= sys_ready_d;
            sys_ready <= sys_ready_d;
        end
    end

    assign lock_loss_evt = (state == ST_RUN) && !lk;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)
            lock_loss_count <= '0;
        else
            lock_loss_count <= next_count(lock_loss_count, clear_counts, lock_loss_evt);
    end

`ifdef PLL_SUP_RETRY_EN
    logic retry_evt;

    assign retry_evt = (state == ST_WAIT_LOCK) && !lk && (cyc == TIMEOUT_LAST);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n)
            retry_count <= '0;
        else
            retry_count <= next_count(retry_count, clear_counts, retry_evt);
    end
`else
    assign retry_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short cycle parameters; edge numbers are counted
// from the first refclk rising edge after rst_n is released.
module tb_pll_lock_supervisor;

    localparam int P = 4;
    localparam int S = 8;
    localparam int T = 100;
    localparam int W = 4;

    logic         refclk;
    logic         rst_n;
    logic         pll_locked;
    logic         clear_counts;
    logic         pll_rst;
    logic         sys_rst_n;
    logic         sys_ready;
    logic [W-1:0] lock_loss_count;
    logic [W-1:0] retry_count;

    int checks = 0;
    int errors = 0;

    pll_lock_supervisor #(
        .LOCK_STABLE_CYCLES (S),
        .LOCK_TIMEOUT_CYCLES(T),
        .PLL_RST_CYCLES     (P),
        .CNT_W              (W)
    ) dut (
        .refclk         (refclk),
        .rst_n          (rst_n),
        .pll_locked     (pll_locked),
        .clear_counts   (clear_counts),
        .pll_rst        (pll_rst),
        .sys_rst_n      (sys_rst_n),
        .sys_ready      (sys_ready),
        .lock_loss_count(lock_loss_count),
        .retry_count    (retry_count)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Returns 1 ns after a rising edge so outputs are sampled clear of the edge.
    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // Leaves the DUT just released from reset; the next rising edge is edge 0.
    task automatic reset_dut();
        rst_n        = 1'b0;
        pll_locked   = 1'b0;
        clear_counts = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sys_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        pll_locked   = 1'b0;
        clear_counts = 1'b0;
        repeat (3) tick();
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("[TB] FAIL reset_pll_rst got=%b want=1", pll_rst); end
        checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_sys_rst_n got=%b want=0", sys_rst_n); end
        checks++; if (sys_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_sys_ready got=%b want=0", sys_ready); end
        checks++; if (lock_loss_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_lock_loss got=%0d want=0", lock_loss_count); end
        checks++; if (retry_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_retry got=%0d want=0", retry_count); end
    endtask

    task automatic test_bring_up();
        rst_n = 1'b1;
        for (int e = 0; e <= 21; e++) begin
            tick();
            if (e == 10) pll_locked = 1'b1;
            if (e == 3) begin
                checks++; if (pll_rst !== 1'b1) begin errors++; $display("[TB] FAIL bringup_pll_rst_e3 got=%b want=1", pll_rst); end
            end
            if (e == 4) begin
                checks++; if (pll_rst !== 1'b0) begin errors++; $display("[TB] FAIL bringup_pll_rst_e4 got=%b want=0", pll_rst); end
            end
            if (e == 20) begin
                checks++; if ({sys_rst_n, sys_ready} !== 2'b00) begin errors++; $display("[TB] FAIL bringup_e20 got=%b want=00", {sys_rst_n, sys_ready}); end
            end
            if (e == 21) begin
                checks++; if ({sys_rst_n, sys_ready} !== 2'b11) begin errors++; $display("[TB] FAIL bringup_e21 got=%b want=11", {sys_rst_n, sys_ready}); end
            end
        end
        checks++; if ({lock_loss_count, retry_count} !== 8'h00) begin errors++; $display("[TB] FAIL bringup_counts got=%h want=00", {lock_loss_count, retry_count}); end
    endtask

    task automatic test_lock_loss();
        pll_locked = 1'b0;
        tick();
        tick();
        checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("[TB] FAIL loss_edge2_sys_rst_n got=%b want=1", sys_rst_n); end
        tick();
        checks++; if ({sys_rst_n, sys_ready, pll_rst} !== 3'b001) begin errors++; $display("[TB] FAIL loss_edge3_outputs got=%b want=001", {sys_rst_n, sys_ready, pll_rst}); end
        checks++; if (lock_loss_count !== 4'd1) begin errors++; $display("[TB] FAIL loss_count got=%0d want=1", lock_loss_count); end
        pll_locked = 1'b1;
        repeat (3) tick();
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("[TB] FAIL loss_pulse_end got=%b want=1", pll_rst); end
        tick();
        checks++; if (pll_rst !== 1'b0) begin errors++; $display("[TB] FAIL loss_pulse_fall got=%b want=0", pll_rst); end
        repeat (8) tick();
        checks++; if (sys_ready !== 1'b0) begin errors++; $display("[TB] FAIL relock_early got=%b want=0", sys_ready); end
        tick();
        checks++; if ({sys_rst_n, sys_ready} !== 2'b11) begin errors++; $display("[TB] FAIL relock_run got=%b want=11", {sys_rst_n, sys_ready}); end
    endtask

    task automatic test_async_reset();
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        repeat (10) tick();
        checks++; if ({sys_ready, pll_rst, lock_loss_count} !== {2'b00, 4'd2}) begin errors++; $display("[TB] FAIL async_pre_state got=%b want=000010", {sys_ready, pll_rst, lock_loss_count}); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if ({pll_rst, sys_rst_n, sys_ready} !== 3'b100) begin errors++; $display("[TB] FAIL async_outputs got=%b want=100", {pll_rst, sys_rst_n, sys_ready}); end
        checks++; if ({lock_loss_count, retry_count} !== 8'h00) begin errors++; $display("[TB] FAIL async_counts got=%h want=00", {lock_loss_count, retry_count}); end
    endtask

    task automatic test_glitch();
        reset_dut();
        for (int e = 0; e <= 27; e++) begin
            tick();
            if (e == 10) pll_locked = 1'b1;
            if (e == 15) pll_locked = 1'b0;
            if (e == 16) pll_locked = 1'b1;
            if (e == 21) begin
                checks++; if (sys_ready !== 1'b0) begin errors++; $display("[TB] FAIL glitch_e21 got=%b want=0", sys_ready); end
            end
            if (e == 26) begin
                checks++; if (sys_ready !== 1'b0) begin errors++; $display("[TB] FAIL glitch_e26 got=%b want=0", sys_ready); end
            end
            if (e == 27) begin
                checks++; if ({sys_rst_n, sys_ready} !== 2'b11) begin errors++; $display("[TB] FAIL glitch_e27 got=%b want=11", {sys_rst_n, sys_ready}); end
            end
        end
        checks++; if ({lock_loss_count, retry_count} !== 8'h00) begin errors++; $display("[TB] FAIL glitch_counts got=%h want=00", {lock_loss_count, retry_count}); end
    endtask

    task automatic test_clear_collision();
        bit ok;
        bit all_ok;
        reset_dut();
        pll_locked = 1'b1;
        wait_ready(100, ok);
        all_ok = ok;
        for (int n = 0; n < 5; n++) begin
            pll_locked = 1'b0;
            repeat (3) tick();
            pll_locked = 1'b1;
            wait_ready(100, ok);
            all_ok = all_ok & ok;
        end
        checks++; if (all_ok !== 1'b1) begin errors++; $display("[TB] FAIL clear_relock_timeout got=%b want=1", all_ok); end
        checks++; if (lock_loss_count !== 4'd5) begin errors++; $display("[TB] FAIL clear_pre_count got=%0d want=5", lock_loss_count); end
        pll_locked = 1'b0;
        tick();
        tick();
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        checks++; if (lock_loss_count !== 4'd1) begin errors++; $display("[TB] FAIL clear_collision got=%0d want=1", lock_loss_count); end
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        checks++; if (lock_loss_count !== 4'd0) begin errors++; $display("[TB] FAIL clear_plain got=%0d want=0", lock_loss_count); end
    endtask

    task automatic test_timeout();
`ifdef PLL_SUP_RETRY_EN
        reset_dut();
        for (int e = 0; e <= 2080; e++) begin
            tick();
            if (e == 103) begin
                checks++; if ({pll_rst, retry_count} !== {1'b0, 4'd0}) begin errors++; $display("[TB] FAIL timeout_e103 got=%b want=00000", {pll_rst, retry_count}); end
            end
            if (e == 104) begin
                checks++; if ({pll_rst, retry_count} !== {1'b1, 4'd1}) begin errors++; $display("[TB] FAIL timeout_e104 got=%b want=10001", {pll_rst, retry_count}); end
            end
            if (e == 107) begin
                checks++; if (pll_rst !== 1'b1) begin errors++; $display("[TB] FAIL timeout_e107 got=%b want=1", pll_rst); end
            end
            if (e == 108) begin
                checks++; if (pll_rst !== 1'b0) begin errors++; $display("[TB] FAIL timeout_e108 got=%b want=0", pll_rst); end
            end
            if (e == 208) begin
                checks++; if ({pll_rst, retry_count} !== {1'b1, 4'd2}) begin errors++; $display("[TB] FAIL timeout_e208 got=%b want=10010", {pll_rst, retry_count}); end
            end
            if (e == 1456) begin
                checks++; if (retry_count !== 4'd14) begin errors++; $display("[TB] FAIL timeout_14 got=%0d want=14", retry_count); end
            end
            if (e == 1560) begin
                checks++; if (retry_count !== 4'd15) begin errors++; $display("[TB] FAIL timeout_15 got=%0d want=15", retry_count); end
            end
            if (e == 2080) begin
                checks++; if (retry_count !== 4'd15) begin errors++; $display("[TB] FAIL timeout_sat got=%0d want=15", retry_count); end
            end
        end
        checks++; if (lock_loss_count !== 4'd0) begin errors++; $display("[TB] FAIL timeout_lock_loss got=%0d want=0", lock_loss_count); end
`else
        int highs;
        highs = 0;
        reset_dut();
        for (int e = 0; e <= 400; e++) begin
            tick();
            if (e >= 4 && pll_rst !== 1'b0) highs++;
        end
        checks++; if (highs !== 0) begin errors++; $display("[TB] FAIL noretry_pll_rst_highs got=%0d want=0", highs); end
        checks++; if (retry_count !== 4'd0) begin errors++; $display("[TB] FAIL noretry_count got=%0d want=0", retry_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_bring_up();
        test_lock_loss();
        test_async_reset();
        test_glitch();
        test_clear_collision();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
